// File: rtl/core_launch_sequencer.sv
// core_launch_sequencer: loads a program into a core over the network, writes its PC,
// then watches the core until it finishes, errors or times out.
module core_launch_sequencer #(
   parameter int IMEM_ADDR_W = 10,
   parameter int INSTR_W     = 16,
   parameter int CORE_ID     = 0,
   parameter int TIMEOUT_W   = 20
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic                   start_i,
   input  logic [IMEM_ADDR_W-1:0] prog_len_i,
   input  logic [IMEM_ADDR_W-1:0] start_pc_i,
   output logic [IMEM_ADDR_W-1:0] rom_addr_o,
   input  logic [INSTR_W-1:0]     rom_data_i,
   output logic                   net_valid_o,
   input  logic                   net_ready_i,
   output logic [2:0]             net_op_o,
   output logic [IMEM_ADDR_W-1:0] net_addr_o,
   output logic [31:0]            net_data_o,
   output logic [4:0]             net_id_o,
   input  logic [1:0]             core_state_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic                   timeout_o,
   output logic [TIMEOUT_W-1:0]   run_cycles_o
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND_INSTR, S_SEND_PC, S_WAIT_RUN, S_WAIT_DONE} state_t;
   localparam logic [1:0] CORE_IDLE = 2'd0, CORE_RUN = 2'd1, CORE_ERR = 2'd2;
   state_t                 state, state_nxt;
   logic [IMEM_ADDR_W-1:0] idx, idx_nxt, len, pc;
   logic [INSTR_W-1:0]     word;
   logic [TIMEOUT_W-1:0]   wait_cnt, wait_nxt, run_nxt;
   logic                   acc;
   assign acc      = net_valid_o & net_ready_i;
   assign idx_nxt  = idx + IMEM_ADDR_W'(1);
   assign wait_nxt = wait_cnt + TIMEOUT_W'(1);
   assign run_nxt  = run_cycles_o + TIMEOUT_W'(1);
   assign net_id_o = 5'(CORE_ID);
   always_ff @(posedge clk or negedge n_reset)
      if (!n_reset) state <= S_IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:       if (start_i) state_nxt = (prog_len_i != '0) ? S_FETCH : S_SEND_PC;
         S_FETCH:      state_nxt = S_SEND_INSTR;
         S_SEND_INSTR: if (acc) state_nxt = (idx_nxt == len) ? S_SEND_PC : S_FETCH;
         S_SEND_PC:    if (acc) state_nxt = S_WAIT_RUN;
         S_WAIT_RUN:   state_nxt = (core_state_i == CORE_ERR || (core_state_i == CORE_IDLE && &wait_nxt)) ? S_IDLE :
                                   (core_state_i == CORE_RUN) ? S_WAIT_DONE : S_WAIT_RUN;
         S_WAIT_DONE:  if (core_state_i == CORE_IDLE || core_state_i == CORE_ERR || &run_nxt) state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
   end
   always_comb begin
      net_valid_o = state == S_SEND_INSTR || state == S_SEND_PC;
      net_op_o    = (state == S_SEND_INSTR) ? 3'd1 : (state == S_SEND_PC) ? 3'd3 : 3'd0;
      net_addr_o  = (state == S_SEND_INSTR) ? idx : '0;
      net_data_o  = (state == S_SEND_INSTR) ? 32'(word) : (state == S_SEND_PC) ? 32'(pc) : 32'd0;
      busy_o      = state != S_IDLE;
   end
   // Error is checked before the counter so a simultaneous ERR never reports a timeout.
   always_ff @(posedge clk or negedge n_reset)
      if (!n_reset) begin
         idx <= '0;
         len <= '0;
         pc <= '0;
         word <= '0;
         rom_addr_o <= '0;
         done_o <= 1'b0;
         err_o <= 1'b0;
         timeout_o <= 1'b0;
         run_cycles_o <= '0;
         wait_cnt <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            S_IDLE: if (start_i) begin
               err_o <= 1'b0;
               timeout_o <= 1'b0;
               run_cycles_o <= '0;
               wait_cnt <= '0;
               idx <= '0;
               rom_addr_o <= '0;
               len <= prog_len_i;
               pc <= start_pc_i;
            end
            S_FETCH: word <= rom_data_i;
            S_SEND_INSTR: if (acc) begin
               idx <= idx_nxt;
               if (idx_nxt != len) rom_addr_o <= idx_nxt;
            end
            S_WAIT_RUN:
               if (core_state_i == CORE_ERR) err_o <= 1'b1;
               else if (core_state_i == CORE_IDLE) begin
                  wait_cnt <= wait_nxt;
                  timeout_o <= &wait_nxt;
               end
            S_WAIT_DONE: begin
               done_o <= core_state_i == CORE_IDLE;
               if (core_state_i == CORE_ERR) err_o <= 1'b1;
               else if (core_state_i != CORE_IDLE) begin
                  run_cycles_o <= run_nxt;
                  timeout_o <= &run_nxt;
               end
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_core_launch_sequencer.sv
// tb_core_launch_sequencer: directed checks of load, PC write, run monitoring,
// backpressure, error, timeout and async reset.
module tb_core_launch_sequencer;
   logic        clk = 1'b0, n_reset, start, start2, ready;
   logic [9:0]  prog_len, start_pc, rom_addr, rom_addr2, addr, addr2;
   logic [15:0] rom [0:1023];
   logic [15:0] rom_data, rom_data2;
   logic [2:0]  op, op2;
   logic [31:0] data, data2;
   logic [4:0]  id, id2;
   logic [1:0]  core;
   logic        valid, valid2, busy, busy2, done, done2, err, err2, tmo, tmo2;
   logic [19:0] rc;
   logic [3:0]  rc2;
   logic [15:0] pat;
   int          checks = 0, failures = 0;
   always #5 clk = ~clk;
   assign rom_data  = rom[rom_addr];
   assign rom_data2 = rom[rom_addr2];
   core_launch_sequencer dut (
      .clk(clk), .n_reset(n_reset), .start_i(start), .prog_len_i(prog_len), .start_pc_i(start_pc),
      .rom_addr_o(rom_addr), .rom_data_i(rom_data), .net_valid_o(valid), .net_ready_i(ready),
      .net_op_o(op), .net_addr_o(addr), .net_data_o(data), .net_id_o(id), .core_state_i(core),
      .busy_o(busy), .done_o(done), .err_o(err), .timeout_o(tmo), .run_cycles_o(rc));
   core_launch_sequencer #(.TIMEOUT_W(4)) dut_t (
      .clk(clk), .n_reset(n_reset), .start_i(start2), .prog_len_i(prog_len), .start_pc_i(start_pc),
      .rom_addr_o(rom_addr2), .rom_data_i(rom_data2), .net_valid_o(valid2), .net_ready_i(ready),
      .net_op_o(op2), .net_addr_o(addr2), .net_data_o(data2), .net_id_o(id2), .core_state_i(core),
      .busy_o(busy2), .done_o(done2), .err_o(err2), .timeout_o(tmo2), .run_cycles_o(rc2));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   // Drives ready (always 1, or the backpressure pattern) and checks every accepted
   // packet against the expected INSTR sequence followed by one PC packet.
   task automatic xfer(input int n, input logic [9:0] pc, input bit bp);
      int k = 0;
      logic pend = 1'b0;
      logic [2:0] pop = '0;
      logic [9:0] pad = '0;
      logic [31:0] pdat = '0;
      for (int c = 0; c < 200 && k <= n; c++) begin
         if (pend) begin
            chk("hold_op", 32'(op), 32'(pop));
            chk("hold_addr", 32'(addr), 32'(pad));
            chk("hold_data", data, pdat);
         end
         ready = bp ? pat[c % 16] : 1'b1;
         if (valid && ready) begin
            chk("pkt_op", 32'(op), (k < n) ? 32'd1 : 32'd3);
            chk("pkt_addr", 32'(addr), (k < n) ? 32'(k) : 32'd0);
            chk("pkt_data", data, (k < n) ? 32'(rom[k]) : 32'(pc));
            k++;
         end
         pend = valid && !ready;
         pop = op;
         pad = addr;
         pdat = data;
         @(negedge clk);
      end
      chk("pkt_count", 32'(k), 32'(n + 1));
   endtask
   initial begin
      n_reset = 1'b0; start = 1'b0; start2 = 1'b0; ready = 1'b0; core = 2'd0;
      prog_len = '0; start_pc = '0; pat = 16'b0110_1001_1101_0010;
      for (int i = 0; i < 1024; i++) rom[i] = (i < 4) ? 16'(16'h1111 * (i + 1)) : 16'(i);
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_op", 32'(op), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flags", {29'd0, done, err, tmo}, 32'd0);
      chk("rst_rc", rc, 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_id", 32'(id), 32'd0);
      n_reset = 1'b1;
      // async reset while an INSTR packet is waiting for ready
      @(negedge clk) prog_len = 10'd2; start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      chk("mid_valid", 32'(valid), 32'd1);
      chk("mid_op", 32'(op), 32'd1);
      #2 n_reset = 1'b0;
      #1 chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_op", 32'(op), 32'd0);
      @(negedge clk) n_reset = 1'b1;
      // 4-word load, run for 10 cycles
      @(negedge clk) prog_len = 10'd4; start_pc = 10'h123; start = 1'b1;
      @(negedge clk) start = 1'b0;
      xfer(4, 10'h123, 1'b0);
      chk("wr_valid", 32'(valid), 32'd0);
      chk("wr_busy", 32'(busy), 32'd1);
      core = 2'd1;
      repeat (11) @(negedge clk);
      chk("run_rc10", rc, 32'd10);
      chk("run_done_early", 32'(done), 32'd0);
      core = 2'd0;
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_rc", rc, 32'd10);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_err", 32'(err), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("rc_held", rc, 32'd10);
      // 3-word load under backpressure
      prog_len = 10'd3; start_pc = 10'h2a; start = 1'b1;
      @(negedge clk) start = 1'b0;
      xfer(3, 10'h2a, 1'b1);
      core = 2'd1;
      @(negedge clk) core = 2'd0;
      @(negedge clk);
      chk("bp_done", 32'(done), 32'd1);
      chk("bp_rc", rc, 32'd0);
      // zero-length program, then core errors
      @(negedge clk) prog_len = 10'd0; start_pc = 10'd5; start = 1'b1;
      @(negedge clk) start = 1'b0;
      xfer(0, 10'd5, 1'b0);
      repeat (5) @(negedge clk);
      chk("len0_wait_busy", 32'(busy), 32'd1);
      chk("len0_no_pkt", 32'(valid), 32'd0);
      core = 2'd1;
      @(negedge clk);
      @(negedge clk);
      chk("err_pre_done", 32'(done), 32'd0);
      core = 2'd2;
      @(negedge clk);
      chk("err_set", 32'(err), 32'd1);
      chk("err_no_done", 32'(done), 32'd0);
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_tmo", 32'(tmo), 32'd0);
      chk("err_rc", rc, 32'd1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("err_cleared", 32'(err), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_rc", rc, 32'd0);
      // 4-bit timeout instance stuck in RUN
      core = 2'd1; ready = 1'b1; start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      repeat (16) @(negedge clk);
      chk("tmo_pre_busy", 32'(busy2), 32'd1);
      chk("tmo_pre_flag", 32'(tmo2), 32'd0);
      chk("tmo_pre_rc", 32'(rc2), 32'd14);
      @(negedge clk);
      chk("tmo_flag", 32'(tmo2), 32'd1);
      chk("tmo_rc", 32'(rc2), 32'd15);
      chk("tmo_busy", 32'(busy2), 32'd0);
      chk("tmo_no_done_err", {30'd0, done2, err2}, 32'd0);
      @(negedge clk);
      chk("tmo_sticky", 32'(tmo2), 32'd1);
      chk("tmo_rc_held", 32'(rc2), 32'd15);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
